// File: rtl/sevga_pkg.sv
// Shared types and constants for the VGA/VRAM blocks.
package sevga_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam logic [2:0] WRITE_SLOT_DEF = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } wrState_t;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [7:0]             data;
    } wrEntry_t;

endpackage

// File: rtl/vram_write_engine_if.sv
// Snooped-write handshake plus the VRAM SRAM bus driven by the write engine.
interface vram_write_engine_if
    import sevga_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
);

    logic              wrValid;
    logic [ADDR_W-1:0] wrAddr;
    logic [7:0]        wrData;
    logic              wrReady;

    logic [ADDR_W-1:0] vramAddr;
    logic [7:0]        vramDataOut;
    logic              vramDataOE;
    logic              nvramWE;
    logic              vramBusy;

    modport master (
        output wrValid, wrAddr, wrData,
        input  wrReady, vramAddr, vramDataOut, vramDataOE, nvramWE, vramBusy
    );

    modport slave (
        input  wrValid, wrAddr, wrData,
        output wrReady, vramAddr, vramDataOut, vramDataOE, nvramWE, vramBusy
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact occupancy; caller guarantees no push when full
// unless a pop happens in the same cycle, and no pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] popData,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign popData = mem[rdPtr];
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/vram_write_engine.sv
// Drains buffered CPU byte writes into the shared VRAM SRAM using the free
// video-fetch slot (or any cycle in blanking) as a setup/strobe/hold write.
module vram_write_engine
    import sevga_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter logic [2:0] WRITE_SLOT = WRITE_SLOT_DEF,
    parameter int         ADDR_W     = VRAM_ADDR_W,
    parameter int         LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic              pixClk,
    input  logic              reset,
    // "sequence" is a reserved word in SV, hence the renamed port
    input  logic [2:0]        pixSequence,
    input  logic              vidBlank,
    vram_write_engine_if.slave bus,
    output logic              overflow,
    output logic [LVL_W-1:0]  fifoLevel
);

    wrState_t          state;
    logic              start;
    logic              push;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [ADDR_W+7:0] headEntry;

    logic [ADDR_W-1:0] addrQ;
    logic [7:0]        dataQ;
    logic              oeQ;
    logic              nweQ;
    logic              busyQ;

    // Start only looks at the registered level, so a write pushed this cycle
    // can never be popped in the same cycle.
    assign start       = (state == IDLE) && !fifoEmpty
                         && (vidBlank || (pixSequence == WRITE_SLOT));
    assign bus.wrReady = !reset && !fifoFull;
    // A full FIFO still takes a write when the head is leaving on this edge.
    assign push        = bus.wrValid && !reset && (!fifoFull || start);

    sync_fifo #(
        .WIDTH (ADDR_W + 8),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) uFifo (
        .clk      (pixClk),
        .rst      (reset),
        .push     (push),
        .pop      (start),
        .pushData ({bus.wrAddr, bus.wrData}),
        .popData  (headEntry),
        .level    (fifoLevel),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge pixClk) begin
        if (reset) begin
            state    <= IDLE;
            addrQ    <= '0;
            dataQ    <= '0;
            oeQ      <= 1'b0;
            nweQ     <= 1'b1;
            busyQ    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (bus.wrValid && !push) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETUP;
                        addrQ <= headEntry[ADDR_W+7:8];
                        dataQ <= headEntry[7:0];
                        busyQ <= 1'b1;
                        oeQ   <= 1'b1;
                        nweQ  <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    nweQ  <= 1'b0;
                end
                STROBE: begin
                    state <= HOLD;
                    nweQ  <= 1'b1;
                end
                HOLD: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                    oeQ   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vramAddr    = addrQ;
    assign bus.vramDataOut = dataQ;
    assign bus.vramDataOE  = oeQ;
    assign bus.nvramWE     = nweQ;
    assign bus.vramBusy    = busyQ;

endmodule

// File: tb/tb_vram_write_engine.sv
// Self-checking bench for vram_write_engine: vector tables, hand-written
// corner sequences, and a scoreboard matched against every SRAM strobe.
module tb_vram_write_engine;
    import sevga_pkg::*;

    localparam logic [2:0] SLOT = 3'd4;

    typedef struct {
        logic        busy;
        logic        nwe;
        logic [2:0]  level;
    } seqExp_t;

    typedef struct {
        logic        valid;
        logic [12:0] addr;
        logic [7:0]  data;
        logic        expReady;
        logic [2:0]  expLevel;
        logic        expOvf;
    } fillVec_t;

    logic        pixClk = 1'b0;
    logic        reset;
    logic [2:0]  seq;
    logic        vidBlank;
    logic        overflow;
    logic [2:0]  fifoLevel;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic        checkSlot = 1'b0;
    logic        prevLow = 1'b0;
    wrEntry_t    sb[$];
    int unsigned strobeTimes[$];

    vram_write_engine_if #(.ADDR_W(13)) bus ();

    vram_write_engine #(
        .DEPTH      (4),
        .WRITE_SLOT (SLOT),
        .ADDR_W     (13),
        .LVL_W      (3)
    ) dut (
        .pixClk      (pixClk),
        .reset       (reset),
        .pixSequence (seq),
        .vidBlank    (vidBlank),
        .bus         (bus),
        .overflow    (overflow),
        .fifoLevel   (fifoLevel)
    );

    always #5 pixClk = ~pixClk;
    always @(posedge pixClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pixClk);
        #1;
        seq = seq + 3'd1;
    endtask

    task automatic waitSeq(input logic [2:0] s);
        for (int i = 0; i < 8 && seq != s; i++) step();
    endtask

    task automatic waitDrain(input int limit);
        int i;
        for (i = 0; i < limit && !(fifoLevel == 3'd0 && bus.vramBusy == 1'b0); i++) step();
        check("drainDone", (fifoLevel == 3'd0 && bus.vramBusy == 1'b0), 1);
    endtask

    task automatic drive(input logic v, input logic [12:0] a, input logic [7:0] d);
        bus.wrValid = v;
        bus.wrAddr  = a;
        bus.wrData  = d;
    endtask

    // Scoreboard: every strobe must match the oldest outstanding accepted write.
    always @(negedge pixClk) begin
        wrEntry_t e;
        if (bus.nvramWE === 1'b0) begin
            check("strobeSingle", prevLow, 0);
            check("strobeBusyOE", {bus.vramBusy, bus.vramDataOE}, 2'b11);
            if (checkSlot) check("strobeSlot", seq, 3'(SLOT + 3'd2));
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpectedWrite actual=%0h/%0h required=none", bus.vramAddr, bus.vramDataOut);
            end else begin
                e = sb.pop_front();
                check("wrAddr", bus.vramAddr, e.addr);
                check("wrData", bus.vramDataOut, e.data);
            end
            strobeTimes.push_back(cyc);
        end
        prevLow = (bus.nvramWE === 1'b0);
    end

    initial begin
        seqExp_t     t1[7];
        fillVec_t    fv[6];
        wrEntry_t    burst[4];
        int unsigned pushCyc;
        int          found;

        t1[0] = '{1'b0, 1'b1, 3'd1};
        t1[1] = '{1'b0, 1'b1, 3'd1};
        t1[2] = '{1'b0, 1'b1, 3'd1};
        t1[3] = '{1'b1, 1'b1, 3'd0};
        t1[4] = '{1'b1, 1'b0, 3'd0};
        t1[5] = '{1'b1, 1'b1, 3'd0};
        t1[6] = '{1'b0, 1'b1, 3'd0};

        fv[0] = '{1'b1, 13'h0200, 8'h11, 1'b1, 3'd1, 1'b0};
        fv[1] = '{1'b1, 13'h0201, 8'h22, 1'b1, 3'd2, 1'b0};
        fv[2] = '{1'b1, 13'h0202, 8'h33, 1'b1, 3'd3, 1'b0};
        fv[3] = '{1'b1, 13'h0203, 8'h44, 1'b1, 3'd4, 1'b0};
        fv[4] = '{1'b1, 13'h1FFF, 8'hFF, 1'b0, 3'd4, 1'b1};
        fv[5] = '{1'b0, 13'h0000, 8'h00, 1'b0, 3'd4, 1'b1};

        burst[0] = '{13'h0010, 8'h01};
        burst[1] = '{13'h0011, 8'h02};
        burst[2] = '{13'h1000, 8'h03};
        burst[3] = '{13'h0ABC, 8'h04};

        seq = 3'd0;
        reset = 1'b1;
        vidBlank = 1'b0;
        drive(1'b0, 13'h0, 8'h0);
        repeat (3) step();

        check("rstNWE", bus.nvramWE, 1);
        check("rstOE", bus.vramDataOE, 0);
        check("rstBusy", bus.vramBusy, 0);
        check("rstAddr", bus.vramAddr, 0);
        check("rstData", bus.vramDataOut, 0);
        check("rstOvf", overflow, 0);
        check("rstLevel", fifoLevel, 0);
        check("rstReady", bus.wrReady, 0);
        reset = 1'b0;
        #1;
        check("readyAfterRst", bus.wrReady, 1);

        // Single write in active video, pushed at sequence 1
        checkSlot = 1'b1;
        waitSeq(3'd1);
        drive(1'b1, 13'h0123, 8'hA5);
        check("t1Ready", bus.wrReady, 1);
        sb.push_back('{13'h0123, 8'hA5});
        step();
        drive(1'b0, 13'h0, 8'h0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t1Busy%0d", i), bus.vramBusy, t1[i].busy);
            check($sformatf("t1OE%0d", i), bus.vramDataOE, t1[i].busy);
            check($sformatf("t1NWE%0d", i), bus.nvramWE, t1[i].nwe);
            check($sformatf("t1Level%0d", i), fifoLevel, t1[i].level);
            if (i == 3) check("t1AddrLoaded", bus.vramAddr, 13'h0123);
            step();
        end

        // Back-to-back writes in blanking
        checkSlot = 1'b0;
        vidBlank = 1'b1;
        strobeTimes.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, burst[i].addr, burst[i].data);
            check($sformatf("burstReady%0d", i), bus.wrReady, 1);
            sb.push_back(burst[i]);
            step();
        end
        drive(1'b0, 13'h0, 8'h0);
        waitDrain(40);
        check("burstCount", strobeTimes.size(), 4);
        for (int i = 1; i < 4 && i < strobeTimes.size(); i++)
            check($sformatf("burstGap%0d", i), strobeTimes[i] - strobeTimes[i-1], 4);

        // Fill to DEPTH in active video, then a dropped fifth write
        vidBlank = 1'b0;
        checkSlot = 1'b1;
        strobeTimes.delete();
        waitSeq(3'd5);
        for (int i = 0; i < 6; i++) begin
            drive(fv[i].valid, fv[i].addr, fv[i].data);
            check($sformatf("fillReady%0d", i), bus.wrReady, fv[i].expReady);
            if (fv[i].valid && fv[i].expReady) sb.push_back('{fv[i].addr, fv[i].data});
            step();
            check($sformatf("fillLevel%0d", i), fifoLevel, fv[i].expLevel);
            check($sformatf("fillOvf%0d", i), overflow, fv[i].expOvf);
        end
        drive(1'b0, 13'h0, 8'h0);
        waitDrain(80);
        check("ovfSticky", overflow, 1);
        check("ovfSbEmpty", sb.size(), 0);
        check("ovfCount", strobeTimes.size(), 4);
        for (int i = 1; i < 4 && i < strobeTimes.size(); i++)
            check($sformatf("ovfGap%0d", i), strobeTimes[i] - strobeTimes[i-1], 8);

        // Reset clears overflow; then full FIFO with push coinciding with pop
        reset = 1'b1;
        step();
        step();
        check("rst2Ovf", overflow, 0);
        check("rst2Level", fifoLevel, 0);
        reset = 1'b0;
        strobeTimes.delete();
        waitSeq(3'd5);
        for (int i = 0; i < 4; i++) begin
            drive(fv[i].valid, fv[i].addr, fv[i].data);
            sb.push_back('{fv[i].addr, fv[i].data});
            step();
            check($sformatf("refillLevel%0d", i), fifoLevel, fv[i].expLevel);
        end
        drive(1'b0, 13'h0, 8'h0);
        waitSeq(SLOT);
        check("ppLevelBefore", fifoLevel, 4);
        drive(1'b1, 13'h0A5A, 8'h5A);
        check("ppReadyLow", bus.wrReady, 0);
        sb.push_back('{13'h0A5A, 8'h5A});
        step();
        drive(1'b0, 13'h0, 8'h0);
        check("ppLevel", fifoLevel, 4);
        check("ppNoOvf", overflow, 0);
        check("ppBusy", bus.vramBusy, 1);
        waitDrain(80);
        check("ppCount", strobeTimes.size(), 5);
        check("ppSbEmpty", sb.size(), 0);

        // Push at the write slot with an empty FIFO: no fall-through
        strobeTimes.delete();
        waitSeq(SLOT);
        drive(1'b1, 13'h0777, 8'h3C);
        sb.push_back('{13'h0777, 8'h3C});
        pushCyc = cyc;
        step();
        drive(1'b0, 13'h0, 8'h0);
        check("nftBusy", bus.vramBusy, 0);
        check("nftLevel", fifoLevel, 1);
        waitDrain(40);
        check("nftCount", strobeTimes.size(), 1);
        if (strobeTimes.size() > 0) check("nftDelay", strobeTimes[0] - pushCyc, 10);

        // Reset during STROBE
        checkSlot = 1'b0;
        vidBlank = 1'b1;
        strobeTimes.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, burst[i].addr, burst[i].data);
            sb.push_back(burst[i]);
            step();
        end
        drive(1'b0, 13'h0, 8'h0);
        found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            if (bus.nvramWE === 1'b0) found = 1;
            else step();
        end
        check("strobeReached", found, 1);
        reset = 1'b1;
        step();
        check("midRstNWE", bus.nvramWE, 1);
        check("midRstBusy", bus.vramBusy, 0);
        check("midRstOE", bus.vramDataOE, 0);
        check("midRstLevel", fifoLevel, 0);
        check("midRstReady", bus.wrReady, 0);
        reset = 1'b0;
        sb.delete();
        repeat (24) step();
        check("noWriteAfterRst", strobeTimes.size(), 1);
        check("idleAfterRst", {bus.vramBusy, fifoLevel}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
